// File: rtl/uart_pkg.sv
// Shared types for the buffered UART transmitter: FSM states and parity modes.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE2} uart_parity_e;

  // Wide enough to index 9 data bits or 2 stop bits.
  localparam int unsigned BIT_IDX_W = 4;

endpackage

// File: rtl/uart_tx_stream_if.sv
// Valid/ready word stream feeding the UART transmitter.
`timescale 1ns/1ps
interface uart_tx_stream_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_BITS-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full/empty
// come from comparing the MSBs.
`timescale 1ns/1ps
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = CW'(wr_ptr_q - rd_ptr_q);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: stream in, FIFO, start/data/[parity]/stop out.
// Define UART_TX_PARITY_EN to add the parity_mode port and the PARITY state.
`timescale 1ns/1ps
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4,
  parameter int DIV_W     = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  uart_tx_stream_if.slave            s_if,
  input  logic [DIV_W-1:0]           clk_div,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                 parity_mode,
`endif
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam logic [BIT_IDX_W-1:0] LAST_DATA = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_STOP = BIT_IDX_W'(STOP_BITS - 1);

  uart_tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
`endif

  logic                   pop;
  logic                   load;
  logic                   bit_end;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign s_if.s_ready = !fifo_full;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (s_if.s_valid && !fifo_full),
    .pop   (pop),
    .din   (s_if.s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end = (cnt_q == div_q);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    load    = 1'b0;
    cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            idx_d = '0;
            // Chain straight into the next start bit when more words wait.
            if (!fifo_empty) load = 1'b1;
            else             state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame setup: divisor and parity are frozen for the whole frame.
    if (load) begin
      pop     = 1'b1;
      shift_d = fifo_dout;
      div_d   = clk_div;
      cnt_d   = '0;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_en_d  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_bit_d = (^fifo_dout) ^ (parity_mode == PAR_ODD);
`endif
    end

    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_bit_q;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_q != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed self-checking bench for uart_tx_stream (1 and 2 stop-bit instances).
`timescale 1ns/1ps
module tb_uart_tx_stream;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] div0, div1;
`ifdef UART_TX_PARITY_EN
  logic [1:0]  pmode;
`endif
  logic        tx0, busy0, tx1, busy1;
  logic [2:0]  cnt0, cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  logic tx_log[$];
  logic tx2_log[$];
  logic busy_log[$];

  always #5 clk = ~clk;

  uart_tx_stream_if #(.DATA_BITS(DB)) if0 ();
  uart_tx_stream_if #(.DATA_BITS(DB)) if1 ();

  uart_tx_stream #(.DATA_BITS(DB), .STOP_BITS(1), .DEPTH(4), .DIV_W(16)) u_dut0 (
    .clk        (clk),
    .rstn       (rstn),
    .s_if       (if0),
    .clk_div    (div0),
`ifdef UART_TX_PARITY_EN
    .parity_mode(pmode),
`endif
    .tx         (tx0),
    .busy       (busy0),
    .fifo_count (cnt0)
  );

  uart_tx_stream #(.DATA_BITS(DB), .STOP_BITS(2), .DEPTH(4), .DIV_W(16)) u_dut1 (
    .clk        (clk),
    .rstn       (rstn),
    .s_if       (if1),
    .clk_div    (div1),
`ifdef UART_TX_PARITY_EN
    .parity_mode(pmode),
`endif
    .tx         (tx1),
    .busy       (busy1),
    .fifo_count (cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tx_log.push_back(tx0);
    tx2_log.push_back(tx1);
    busy_log.push_back(busy0);
  endtask

  task automatic capture(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_log();
    tx_log.delete();
    tx2_log.delete();
    busy_log.delete();
  endtask

  task automatic push(input int which, input logic [7:0] w);
    tick();
    if (which == 0) begin
      chk("push_ready0", 32'(if0.s_ready), 1);
      if0.s_valid = 1'b1;
      if0.s_data  = w;
    end else begin
      chk("push_ready1", 32'(if1.s_ready), 1);
      if1.s_valid = 1'b1;
      if1.s_data  = w;
    end
  endtask

  task automatic release_valid();
    tick();
    if0.s_valid = 1'b0;
    if1.s_valid = 1'b0;
  endtask

  function automatic logic sample(input int which, input int i);
    if (i < 0) return 1'bx;
    if (which == 0) return (i < tx_log.size())  ? tx_log[i]  : 1'bx;
    else            return (i < tx2_log.size()) ? tx2_log[i] : 1'bx;
  endfunction

  function automatic int find_zero(input int which, input int from);
    int n;
    n = (which == 0) ? tx_log.size() : tx2_log.size();
    for (int i = from; i < n; i++)
      if (sample(which, i) === 1'b0) return i;
    return -1;
  endfunction

  // pbit < 0 means no parity bit is expected in the frame.
  task automatic check_frame(input string tag, input int which, input int idx,
                             input logic [8:0] word, input int cpb, input int nstop,
                             input int pbit, output int end_idx);
    int   pos;
    int   nb;
    int   ok;
    logic exp;
    pos = idx;
    nb  = 1 + DB + ((pbit >= 0) ? 1 : 0) + nstop;
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                              exp = 1'b0;
      else if (b <= DB)                        exp = word[b-1];
      else if (pbit >= 0 && b == DB + 1)       exp = pbit[0];
      else                                     exp = 1'b1;
      ok = 0;
      for (int c = 0; c < cpb; c++)
        if (sample(which, pos + c) === exp) ok++;
      n_assert++;
      assert (ok == cpb) else begin
        n_fail++;
        $error("FAIL %s bit%0d: level %b held %0d clocks, required %0d", tag, b, exp, ok, cpb);
      end
      pos += cpb;
    end
    end_idx = pos;
  endtask

  initial begin
    int          z, e, acc, g, p;
    logic [9:0]  v;

    rstn = 1'b0;
    div0 = 16'd3;
    div1 = 16'd3;
`ifdef UART_TX_PARITY_EN
    pmode = 2'b00;
`endif
    if0.s_valid = 1'b0; if0.s_data = '0;
    if1.s_valid = 1'b0; if1.s_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx",     32'(tx0), 1);
    chk("rst_busy",   32'(busy0), 0);
    chk("rst_count",  32'(cnt0), 0);
    chk("rst_ready",  32'(if0.s_ready), 1);
    chk("rst_tx_2stop", 32'(tx1), 1);
    @(negedge clk);
    rstn = 1'b1;
    capture(2);

    // Single 0xA5 frame: latency, bit pattern, length, busy fall
    clear_log();
    push(0, 8'hA5);
    release_valid();
    capture(50);
    chk("t1_tx_after_accept", 32'(tx_log[1]), 1);
    chk("t1_tx_edge1",        32'(tx_log[2]), 1);
    z = find_zero(0, 0);
    chk("t1_start_index", 32'(z), 3);
    chk("t1_busy_mid", 32'(busy_log[3]), 1);
    for (int b = 0; b < 10; b++) v[b] = sample(0, 3 + b*4 + 2);
    chk("t1_pattern", 32'(v), 32'(10'b1101001010));
    check_frame("t1_frame", 0, z, 9'h0A5, 4, 1, -1, e);
    chk("t1_idle_after", 32'(tx_log[e]), 1);
    chk("t1_busy_last_stop", 32'(busy_log[e-1]), 1);
    chk("t1_busy_fall", 32'(busy_log[e]), 0);

    // Streaming: 5 words accepted, back-to-back frames
    clear_log();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if0.s_valid = 1'b1;
      if0.s_data  = 8'(8'h10 + acc);
      if (if0.s_ready === 1'b1) acc++;
    end
    tick();
    if0.s_valid = 1'b0;
    chk("t2_accepted",   32'(acc), 5);
    chk("t2_fifo_count", 32'(cnt0), 4);
    chk("t2_ready_low",  32'(if0.s_ready), 0);
    capture(230);
    z = find_zero(0, 0);
    chk("t2_start_index", 32'(z), 3);
    p = z;
    for (int k = 0; k < 5; k++) begin
      check_frame($sformatf("t2_frame%0d", k), 0, p, 9'(8'h10 + k), 4, 1, -1, p);
    end
    chk("t2_idle_after", 32'(tx_log[p]), 1);
    chk("t2_busy_fall",  32'(busy_log[p]), 0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 even then odd
    clear_log();
    pmode = 2'b01;
    push(0, 8'h07);
    release_valid();
    tick();
    pmode = 2'b10;
    push(0, 8'h07);
    release_valid();
    capture(100);
    z = find_zero(0, 0);
    chk("t3_start_index", 32'(z), 3);
    check_frame("t3_even", 0, z, 9'h007, 4, 1, 1, e);
    chk("t3_even_len", 32'(e - z), 44);
    check_frame("t3_odd", 0, e, 9'h007, 4, 1, 0, p);
    chk("t3_odd_len", 32'(p - e), 44);
    chk("t3_idle_after", 32'(tx_log[p]), 1);
    pmode = 2'b00;
`endif

    // Divisor change mid-frame applies to the next frame only
    clear_log();
    div0 = 16'd0;
    push(0, 8'h3C);
    push(0, 8'h5A);
    release_valid();
    div0 = 16'd9;
    capture(130);
    z = find_zero(0, 0);
    chk("t4_start_index", 32'(z), 3);
    check_frame("t4_fast", 0, z, 9'h03C, 1, 1, -1, e);
    check_frame("t4_slow", 0, e, 9'h05A, 10, 1, -1, p);
    chk("t4_idle_after", 32'(tx_log[p]), 1);
    div0 = 16'd3;

    // Two stop bits: 8 high clocks between last data bit and next start
    clear_log();
    push(1, 8'hFF);
    push(1, 8'hFF);
    release_valid();
    capture(100);
    z = find_zero(1, 0);
    chk("t5_start_index", 32'(z), 3);
    check_frame("t5_frame0", 1, z, 9'h0FF, 4, 2, -1, e);
    g = 0;
    p = z + 36;
    while (p < tx2_log.size() && tx2_log[p] === 1'b1 && g < 100) begin
      g++;
      p++;
    end
    chk("t5_stop_gap", 32'(g), 8);
    check_frame("t5_frame1", 1, e, 9'h0FF, 4, 2, -1, p);
    chk("t5_idle_after", 32'(tx2_log[p]), 1);

    // Asynchronous reset mid-frame discards queued words
    clear_log();
    push(0, 8'h40);
    push(0, 8'h22);
    push(0, 8'h33);
    push(0, 8'h44);
    release_valid();
    chk("t6_count_before", 32'(cnt0), 3);
    chk("t6_busy_before",  32'(busy0), 1);
    capture(6);
    chk("t6_tx_low_in_data", 32'(tx0), 0);
    #1 rstn = 1'b0;
    #1;
    chk("t6_tx_async",  32'(tx0), 1);
    chk("t6_count_rst", 32'(cnt0), 0);
    chk("t6_busy_rst",  32'(busy0), 0);
    chk("t6_ready_rst", 32'(if0.s_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    clear_log();
    capture(100);
    chk("t6_no_frames", 32'(find_zero(0, 0)), 32'hFFFF_FFFF);
    chk("t6_count_after", 32'(cnt0), 0);
    chk("t6_busy_after",  32'(busy0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
